// File: rtl/divu_seq.sv
// divu_seq: multi-cycle unsigned restoring divider, one trial subtraction per clock.
// A start accepted in IDLE runs WIDTH iterations in RUN, then pulses done for one
// cycle in DONE while quotient/remainder/div_by_zero hold the new result.
// Optional feature macro: DIVU_ZERO_CHK_EN -- when defined, a zero divisor skips the
// iterations and reports div_by_zero=1 one clock after the accepting edge; when
// undefined, a zero divisor runs the full iteration sequence and div_by_zero stays 0.
module divu_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] qwork_q, qwork_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef DIVU_ZERO_CHK_EN
    // Set at the accepting edge of a zero-divisor request; the result is posted one clock later.
    logic             zpend_q, zpend_d;
`endif

    logic [WIDTH:0]   trial;
    logic [WIDTH+1:0] sum;
    logic             noBorrow;
    logic [WIDTH:0]   rNext;
    logic [WIDTH-1:0] qNext;
    logic             lastIter;

    // One restoring step: shift the next dividend bit into the partial remainder and try a subtract.
    always_comb begin
        trial    = {r_q[WIDTH-1:0], qwork_q[WIDTH-1]};
        sum      = {1'b0, trial} + {1'b0, ~{1'b0, divisor_q}} + {{(WIDTH+1){1'b0}}, 1'b1};
        noBorrow = sum[WIDTH+1];
        rNext    = noBorrow ? sum[WIDTH:0] : trial;
        qNext    = {qwork_q[WIDTH-2:0], noBorrow};
        lastIter = (cnt_q == CW'(WIDTH - 1));
    end

    // Next-state and datapath control; busy/done are registered from the next state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        qwork_d     = qwork_q;
        divisor_d   = divisor_q;
        r_d         = r_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
`ifdef DIVU_ZERO_CHK_EN
        zpend_d     = zpend_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef DIVU_ZERO_CHK_EN
                if (zpend_q) begin
                    state_d     = DONE;
                    zpend_d     = 1'b0;
                    quotient_d  = '1;
                    remainder_d = qwork_q;
                    dbz_d       = 1'b1;
                end else if (start) begin
                    qwork_d   = dividend;
                    divisor_d = divisor;
                    r_d       = '0;
                    cnt_d     = '0;
                    if (divisor == '0) begin
                        zpend_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
`else
                if (start) begin
                    qwork_d   = dividend;
                    divisor_d = divisor;
                    r_d       = '0;
                    cnt_d     = '0;
                    state_d   = RUN;
                end
`endif
            end
            RUN: begin
                r_d     = rNext;
                qwork_d = qNext;
                cnt_d   = cnt_q + CW'(1);
                if (lastIter) begin
                    state_d     = DONE;
                    quotient_d  = qNext;
                    remainder_d = rNext[WIDTH-1:0];
                    dbz_d       = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            qwork_q     <= '0;
            divisor_q   <= '0;
            r_q         <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef DIVU_ZERO_CHK_EN
            zpend_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            qwork_q     <= qwork_d;
            divisor_q   <= divisor_d;
            r_q         <= r_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef DIVU_ZERO_CHK_EN
            zpend_q     <= zpend_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
